// File: rtl/mxint_dequant_serializer_if.sv
// MxInt block input and fixed-point beat output bundles
// for the MxInt dequantising serializer.
interface mxint_blk_if #(
  parameter int IN_MAN_WIDTH = 8,
  parameter int IN_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE   = 4
);
  logic signed [IN_MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE];
  logic        [IN_EXP_WIDTH-1:0] edata_in;
  logic                           data_in_valid;
  logic                           data_in_ready;

  modport master (
    output mdata_in, edata_in, data_in_valid,
    input  data_in_ready
  );
  modport slave (
    input  mdata_in, edata_in, data_in_valid,
    output data_in_ready
  );
endinterface

interface fxp_beat_if #(
  parameter int OUT_WIDTH       = 16,
  parameter int OUT_PARALLELISM = 2
);
  logic signed [OUT_WIDTH-1:0] data_out [OUT_PARALLELISM];
  logic                        data_out_last;
  logic                        data_out_valid;
  logic                        data_out_ready;

  modport master (
    output data_out, data_out_last, data_out_valid,
    input  data_out_ready
  );
  modport slave (
    input  data_out, data_out_last, data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/mxint_dequant_serializer.sv
// Buffers one MxInt block and streams it out as
// saturated signed fixed point, OUT_PARALLELISM per beat.
module mxint_dequant_serializer #(
  parameter int IN_MAN_WIDTH    = 8,
  parameter int IN_EXP_WIDTH    = 8,
  parameter int OUT_WIDTH       = 16,
  parameter int OUT_FRAC_WIDTH  = 8,
  parameter int BLOCK_SIZE      = 4,
  parameter int OUT_PARALLELISM = 2
) (
  input logic       clk,
  input logic       rst,
  mxint_blk_if.slave blk,
  fxp_beat_if.master beat_o
);
  localparam int BEATS = BLOCK_SIZE / OUT_PARALLELISM;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(OUT_WIDTH + IN_MAN_WIDTH);
  localparam int SW    =
    ((IN_EXP_WIDTH > CW) ? IN_EXP_WIDTH : CW) + 2;
  localparam int WW    = OUT_WIDTH + IN_MAN_WIDTH + 1;
  localparam int EBIAS = 2**(IN_EXP_WIDTH-1) - 1;

  localparam logic signed [SW-1:0] S_OFF =
    SW'(OUT_FRAC_WIDTH - EBIAS - (IN_MAN_WIDTH - 2));
  localparam logic signed [SW-1:0] S_HI = SW'(OUT_WIDTH);
  localparam logic signed [SW-1:0] S_LO = SW'(-IN_MAN_WIDTH);
  localparam logic signed [WW-1:0] WMAX =
    WW'(2**(OUT_WIDTH-1) - 1);
  localparam logic signed [WW-1:0] WMIN = -WMAX;

  logic signed [IN_MAN_WIDTH-1:0] buf_m [BLOCK_SIZE];
  logic signed [IN_MAN_WIDTH-1:0] slice [BEATS][OUT_PARALLELISM];
  logic signed [SW-1:0]           s_q;
  logic signed [SW-1:0]           s_new;
  logic                           full;
  logic [BW-1:0]                  beat;
  logic                           last;
  logic                           in_fire;
  logic                           out_fire;

  function automatic logic signed [OUT_WIDTH-1:0] deq(
    input logic signed [IN_MAN_WIDTH-1:0] m,
    input logic signed [SW-1:0]           sh
  );
    logic signed [WW-1:0] w;
    logic signed [WW-1:0] r;
    logic [SW-1:0]        amt;
    w   = {{(WW-IN_MAN_WIDTH){m[IN_MAN_WIDTH-1]}}, m};
    r   = '0;
    amt = '0;
    if (m == '0) begin
      r = '0;
    end else if (sh > S_HI) begin
      r = m[IN_MAN_WIDTH-1] ? WMIN : WMAX;
    end else if (sh < S_LO) begin
      r = m[IN_MAN_WIDTH-1] ? '1 : '0;
    end else if (!sh[SW-1]) begin
      amt = sh;
      r   = w <<< amt;
      if (r > WMAX)      r = WMAX;
      else if (r < WMIN) r = WMIN;
    end else begin
      amt = -sh;
      r   = w >>> amt;
    end
    return r[OUT_WIDTH-1:0];
  endfunction

  assign last     = full && (beat == BW'(BEATS - 1));
  assign out_fire = full && beat_o.data_out_ready;
  assign blk.data_in_ready =
    !full || (last && beat_o.data_out_ready);
  assign in_fire  = blk.data_in_valid && blk.data_in_ready;
  assign s_new    =
    $signed({{(SW-IN_EXP_WIDTH){1'b0}}, blk.edata_in}) + S_OFF;

  assign beat_o.data_out_valid = full;
  assign beat_o.data_out_last  = last;

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    for (genvar j = 0; j < OUT_PARALLELISM; j++) begin : g_el
      assign slice[k][j] = buf_m[k*OUT_PARALLELISM + j];
    end
  end

  for (genvar j = 0; j < OUT_PARALLELISM; j++) begin : g_lane
    assign beat_o.data_out[j] = deq(slice[beat][j], s_q);
  end

  // Block buffer and shift load on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BLOCK_SIZE; i++) buf_m[i] <= '0;
      s_q <= '0;
    end else if (in_fire) begin
      for (int i = 0; i < BLOCK_SIZE; i++)
        buf_m[i] <= blk.mdata_in[i];
      s_q <= s_new;
    end
  end

  // Occupancy and beat sequencing; accept wins over drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      beat <= '0;
    end else if (in_fire) begin
      full <= 1'b1;
      beat <= '0;
    end else if (out_fire) begin
      if (last) begin
        full <= 1'b0;
        beat <= '0;
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mxint_dequant_serializer.sv
// Randomized scoreboard bench for the MxInt
// dequantising serializer.
module tb_mxint_dequant_serializer;
  localparam int MW = 8;
  localparam int EW = 8;
  localparam int OW = 16;
  localparam int FW = 8;
  localparam int BS = 4;
  localparam int OP = 2;
  localparam int EBIAS = 2**(EW-1) - 1;
  localparam int VMAX = 2**(OW-1) - 1;

  typedef struct {
    int d [OP];
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   rdy_mode = 1;
  int   total = 0;
  int   pass = 0;

  beat_t exp_q [$];
  int    hs_q [$];
  int    acc_q [$];

  bit    held = 0;
  int    hd [OP];
  bit    hl;

  mxint_blk_if #(.IN_MAN_WIDTH(MW), .IN_EXP_WIDTH(EW),
                 .BLOCK_SIZE(BS)) ib ();
  fxp_beat_if #(.OUT_WIDTH(OW), .OUT_PARALLELISM(OP)) ob ();

  mxint_dequant_serializer #(
    .IN_MAN_WIDTH(MW), .IN_EXP_WIDTH(EW), .OUT_WIDTH(OW),
    .OUT_FRAC_WIDTH(FW), .BLOCK_SIZE(BS),
    .OUT_PARALLELISM(OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .blk(ib.slave),
    .beat_o(ob.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint expv);
    total++;
    if (act == expv) pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, expv);
  endtask

  // value = m * 2^s, floor toward -inf, symmetric clamp
  function automatic int ref_elem(int m, int e);
    int s;
    longint v, d;
    s = e - EBIAS - (MW - 2) + FW;
    if (m == 0) return 0;
    if (s > OW) return (m > 0) ? VMAX : -VMAX;
    if (s < -MW) return (m > 0) ? 0 : -1;
    if (s >= 0) begin
      v = longint'(m) * (longint'(1) << s);
      if (v > VMAX) v = VMAX;
      if (v < -VMAX) v = -VMAX;
      return int'(v);
    end
    d = longint'(1) << (-s);
    v = longint'(m) / d;
    if ((longint'(m) % d) != 0 && m < 0) v = v - 1;
    return int'(v);
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: ob.data_out_ready = ($urandom_range(0, 3) != 0);
      2: ob.data_out_ready = 1'b0;
      default: ob.data_out_ready = 1'b1;
    endcase
  end

  task automatic send(input int m [BS], input int e);
    int n;
    beat_t b;
    @(negedge clk);
    for (int i = 0; i < BS; i++) ib.mdata_in[i] = MW'(m[i]);
    ib.edata_in = EW'(e);
    ib.data_in_valid = 1'b1;
    n = 0;
    while (!ib.data_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 0, 1);
      ib.data_in_valid = 1'b0;
      return;
    end
    acc_q.push_back(cyc);
    for (int k = 0; k < BS / OP; k++) begin
      for (int j = 0; j < OP; j++)
        b.d[j] = ref_elem(m[k*OP + j], e);
      b.last = (k == BS / OP - 1);
      exp_q.push_back(b);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    ib.data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pop on handshake, check stability under stall.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", ob.data_out_valid, 1);
        chk("hold_last", ob.data_out_last, hl);
        for (int j = 0; j < OP; j++)
          chk("hold_data", ob.data_out[j], hd[j]);
      end
      if (ob.data_out_valid && ob.data_out_ready) begin
        held = 0;
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          for (int j = 0; j < OP; j++)
            chk("data", ob.data_out[j], b.d[j]);
          chk("last", ob.data_out_last, b.last);
        end
      end else if (ob.data_out_valid) begin
        held = 1;
        hl = ob.data_out_last;
        for (int j = 0; j < OP; j++) hd[j] = ob.data_out[j];
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    int m [BS];
    int e;
    ib.data_in_valid = 1'b0;
    ib.edata_in = '0;
    for (int i = 0; i < BS; i++) ib.mdata_in[i] = '0;
    ob.data_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", ob.data_out_valid, 0);
    chk("rst_last", ob.data_out_last, 0);
    chk("rst_in_ready", ib.data_in_ready, 1);
    chk("rst_data0", ob.data_out[0], 0);
    chk("rst_data1", ob.data_out[1], 0);
    #2 rst = 1'b1;

    rdy_mode = 1;
    hs_q.delete(); acc_q.delete();
    m = '{64, -64, 32, 0};
    send(m, 127);
    idle();
    drain();
    chk("latency", hs_q[0] - acc_q[0], 1);
    chk("beat1_next", hs_q[1] - hs_q[0], 1);

    m = '{-64, -3, 3, 63};    send(m, 120);
    m = '{100, -100, 1, -1};  send(m, 140);
    send(m, 200);
    send(m, 0);
    m = '{-128, 127, -128, 127}; send(m, 133);
    idle();
    drain();

    hs_q.delete(); acc_q.delete();
    m = '{5, -7, 9, -11};  send(m, 126);
    m = '{-1, 2, -3, 4};   send(m, 131);
    idle();
    drain();
    chk("b2b_accept_gap", acc_q[1] - acc_q[0], BS / OP);
    chk("b2b_beats", hs_q.size(), 4);
    chk("b2b_span", hs_q[3] - hs_q[0], 3);

    rdy_mode = 2;
    m = '{17, -33, 66, -99};
    send(m, 128);
    idle();
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", ob.data_out_valid, 1);
      chk("bp_in_ready", ib.data_in_ready, 0);
    end
    rdy_mode = 1;
    drain();

    m = '{10, 20, 30, 40};
    send(m, 127);
    idle();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", ob.data_out_valid, 0);
    chk("arst_last", ob.data_out_last, 0);
    chk("arst_in_ready", ib.data_in_ready, 1);
    chk("arst_data0", ob.data_out[0], 0);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    hs_q.delete(); acc_q.delete();
    m = '{-50, 50, -25, 25};
    send(m, 129);
    idle();
    drain();
    chk("post_rst_latency", hs_q[0] - acc_q[0], 1);
    chk("post_rst_beats", hs_q.size(), 2);

    rdy_mode = 0;
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < BS; i++) begin
        m[i] = int'($urandom_range(0, 255)) - 128;
        if ($urandom_range(0, 7) == 0) m[i] = 0;
      end
      if ($urandom_range(0, 4) != 0)
        e = int'($urandom_range(105, 150));
      else
        e = int'($urandom_range(0, 255));
      send(m, e);
      if ($urandom_range(0, 3) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    idle();
    rdy_mode = 1;
    drain();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mxint_dequant_serializer.md
# mxint_dequant_serializer

Converts normalized MxInt blocks (one shared exponent, BLOCK_SIZE signed mantissas) back to signed fixed point, streaming each block out as OUT_PARALLELISM elements per beat. It sits at the consumer end of an MxInt link, after the MxInt cast stage, and feeds fixed-point datapaths (e.g. activations, residual adds). It buffers one block and supports back-to-back blocks at full throughput.

## Interface
- IN_MAN_WIDTH, 8: mantissa width, two's complement; normalized format is sign.int.(IN_MAN_WIDTH-2) fraction bits
- IN_EXP_WIDTH, 8: exponent width; bias EBIAS = 2^(IN_EXP_WIDTH-1)-1
- OUT_WIDTH, 16: output fixed-point total width, signed
- OUT_FRAC_WIDTH, 8: output fraction bits
- BLOCK_SIZE, 4: mantissas per block
- OUT_PARALLELISM, 2: elements per output beat; must divide BLOCK_SIZE; BEATS = BLOCK_SIZE/OUT_PARALLELISM
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- mdata_in  in  IN_MAN_WIDTH x BLOCK_SIZE (unpacked)  block mantissas
- edata_in  in  IN_EXP_WIDTH  shared exponent, unsigned biased
- data_in_valid / data_in_ready  in / out  1  input handshake
- data_out  out  OUT_WIDTH x OUT_PARALLELISM (unpacked)  fixed-point elements
- data_out_last  out  1  high on final beat of a block
- data_out_valid / data_out_ready  out / in  1  output handshake

## Operation
- State: block buffer (mantissas + exponent), `full` flag, beat counter `beat` (0..BEATS-1), registered signed shift `s`.
- Shift per block, computed at acceptance from edata_in: s = edata_in - EBIAS - (IN_MAN_WIDTH-2) + OUT_FRAC_WIDTH; internal width max(IN_EXP_WIDTH, $clog2(OUT_WIDTH+IN_MAN_WIDTH))+2, signed, no wrap.
- Beat k outputs buffer elements k*OUT_PARALLELISM .. k*OUT_PARALLELISM+OUT_PARALLELISM-1, element j of the slice to data_out[j].
- Per element, MAX = 2^(OUT_WIDTH-1)-1, MIN = -MAX (symmetric):
  - m == 0 -> 0
  - s > OUT_WIDTH -> MAX if m>0, MIN if m<0
  - s < -IN_MAN_WIDTH -> 0 if m>0, -1 if m<0
  - s >= 0: m<<<s, saturated to [MIN, MAX]
  - s < 0: m>>>(-s), arithmetic (floor toward -inf)
- data_out is combinational from registered state only; no combinational path from mdata_in/edata_in to data_out.
- data_out_valid = full; data_out_last = full && beat == BEATS-1.
- data_in_ready = !full || (data_out_last && data_out_ready).
- Output handshake: beat advances; on last beat, full clears unless a new block is accepted in the same cycle.
- Input handshake: buffer, s loaded; beat := 0; full := 1.
- Simultaneous last-beat consume and new accept: new block loads, beat resets to 0, full stays 1; zero bubble.

## Timing
- Reset (rst low, asynchronous): full=0, beat=0, s=0, buffer zeroed; data_out_valid=0, data_out_last=0, data_in_ready=1, data_out all zero. Mid-block reset discards the block; no partial beats after release.
- Latency: block accepted at edge T -> beat 0 valid after edge T (cycle T+1).
- Throughput: one block per BEATS cycles with data_out_ready held high.
- Backpressure: data_out_ready low holds data_out, data_out_last, beat stable; data_out_valid never drops without a handshake.
- BEATS == 1: every beat is last; data_in_ready = !full || data_out_ready.
- Inputs ignored while data_in_ready low; upstream holds per valid/ready rules.

## Test plan
- Defaults (EBIAS=127, s=e-125). Block m={64,-64,32,0}, e=127 (s=2), ready high -> beat0 {256,-256} last=0, beat1 {128,0} last=1, cycles T+1, T+2.
- Right shift/rounding: m={-64,-3,3,63}, e=120 (s=-5) -> {-2,-1},{0,1}.
- Saturation: m={100,-100,1,-1}, e=140 (s=15) -> {32767,-32767},{32767,-32767}; e=200 (s>16) same; e=0 (s=-125) -> {0,-1},{0,-1}.
- Back-to-back: two blocks, valid high continuously, ready high -> 4 consecutive valid beats, no bubble; data_in_ready high only on last-beat cycles after first accept.
- Backpressure: drop data_out_ready for 3 cycles mid-block -> data_out/last stable, data_in_ready low, no loss or duplication.
- Reset mid-block: assert rst after beat0 -> data_out_valid falls immediately (async), data_in_ready=1 after release; next block emits from beat0.
